uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the UART command bus (id/din/write) between two byte-stream requesters and one baud-rate configuration port.
- Grants whole packets round-robin and writes each accepted byte as a txStoreByte command.
- Throttles on the UART's txcount so the 2048-byte TX buffer never overwrites, issues txFlush at packet end, and applies setBaud only once the line has drained.
- Sits between the camera/debug data sources and the uart block.

Parameters:
- INIT_BAUD, 16'd2604, shadow of UART reset baud divisor; used for drain guard timing.
- HIGH_WM, 2040, txcount level at or above which byte acceptance stalls.
- TIMEOUT, 16'd50000, idle-valid cycles while granted before the packet is force-ended.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 byte valid
- req0_data  in  8  requester 0 byte
- req0_last  in  1  requester 0 final byte of packet
- req0_ready  out  1  requester 0 byte accepted when valid&ready
- req1_valid, req1_data, req1_last, req1_ready  same widths/meaning for requester 1
- cfg_baud_valid  in  1  baud change request, held until cfg_baud_ready
- cfg_baud  in  16  new divisor (clk/baud/2)
- cfg_baud_ready  out  1  one-cycle pulse: divisor written
- uart_txcount  in  12  UART TX buffer occupancy
- uart_id  out  16  command id to UART
- uart_din  out  16  command data to UART
- uart_write  out  1  command strobe, one cycle per command
- grant  out  2  one-hot current packet owner, 00 when none
- timeout_pulse  out  1  one-cycle pulse on forced packet end

Behaviour:
- Reset (synchronous, active-high; clock clk): uart_write=0, uart_id=0, uart_din=0, grant=00, all ready=0, cfg_baud_ready=0, timeout_pulse=0, last_grant=1 (so req0 wins first), baud shadow=INIT_BAUD, state=IDLE.
- Reset mid-packet: abandon the packet; issue no flush.
- All UART outputs are registered. A command appears exactly one cycle after the decision. uart_write is high for one cycle per command. At most one command per cycle.
- States:
  - IDLE:
    - If cfg_baud_valid, go to BAUD_WAIT. Baud has priority, but only at packet boundaries.
    - Else if exactly one reqN_valid, grant N and go to STREAM.
    - Else if both valid, grant the requester not equal to last_grant.
    - grant is updated on entry to STREAM.
  - STREAM:
    - ready_N = granted & (uart_txcount <= HIGH_WM-2) & no write issued last cycle. The write-gap rule covers the one-cycle txcount update lag, giving at most one byte every 2 cycles.
    - On valid&ready: next cycle uart_id=16'h0201, uart_din={8'h00,data}, uart_write=1. Clear the timeout counter.
    - If last=1, go to FLUSH.
    - While granted and valid=0, increment the timeout counter. When it reaches TIMEOUT, go to FLUSH and pulse timeout_pulse.
  - FLUSH: emit uart_id=16'h0202, uart_din=0, uart_write=1. Set last_grant=owner, grant=00, go to IDLE. The flush write occurs the cycle after the final byte write (the write-gap rule does not apply to flush).
  - BAUD_WAIT: wait until uart_txcount==0. Then count down a guard of 4*(shadow+1) cycles (covers the in-flight stop bit). A non-zero txcount during the guard restarts the wait. On reaching 0, go to BAUD_SET.
  - BAUD_SET: emit uart_id=16'h0200, uart_din=cfg_baud, uart_write=1. Pulse cfg_baud_ready, load shadow=cfg_baud, go to IDLE.
- Requests arriving during STREAM wait for the packet to end; a packet is never interleaved.
- The non-granted requester's ready is always 0.
- Guard counter is 18 bits wide. Timeout counter is 16 bits and saturates at TIMEOUT.
- uart_txcount >= HIGH_WM holds ready low indefinitely; no timeout is counted while valid=1.

Optional Feature:
- Macro UART_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_bytes0 [15:0], stat_bytes1 [15:0], stat_timeouts [7:0].
  - Byte counters increment per accepted byte; the timeout counter increments per forced end.
  - All counters wrap modulo width and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- After reset, req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with txcount=0 -> writes id 0x0201 din 0x0041/0x0042/0x0043, then id 0x0202 next cycle; grant 01 then 00.
- req0 and req1 both valid continuously with 2-byte packets -> grants alternate 01,10,01,10; no packet interleaving.
- txcount driven to 2039 during a packet -> ready drops, no uart_write; txcount lowered to 2000 -> acceptance resumes.
- cfg_baud_valid with cfg_baud=16'd325 while req1 streams, txcount held at 5 -> no 0x0200 write. Then txcount=0 for 4*2605 cycles -> id 0x0200 din 325 plus cfg_baud_ready pulse. A following baud change uses a guard of 4*326.
- req1 granted, sends one non-last byte, then valid low for TIMEOUT cycles -> flush write, timeout_pulse=1 for one cycle, grant 00; stats stat_timeouts=1 if enabled.
- reset asserted mid-packet after 2 bytes -> next cycle all outputs at reset values, no 0x0202 write; req0 wins the next arbitration.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares the UART command bus between two byte-stream requesters and one
// baud-rate configuration port. Whole packets are granted round-robin and each
// accepted byte becomes a txStoreByte command (id 0x0201). A txFlush command
// (id 0x0202) closes every packet. Byte acceptance is throttled on the UART TX
// buffer occupancy. A baud change (setBaud, id 0x0200) is applied only at a
// packet boundary, and only once the line has fully drained.
//
// Optional feature: define UART_ARB_STATS_EN to add the statistics counters
// stat_bytes0, stat_bytes1 and stat_timeouts.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   reqN_valid/data/last   requester N byte stream (N = 0, 1)
//   reqN_ready             requester N byte accepted when valid & ready
//   cfg_baud_valid         baud change request, held until cfg_baud_ready
//   cfg_baud               new divisor (clk/baud/2)
//   cfg_baud_ready         one-cycle pulse: divisor written to the UART
//   uart_txcount           UART TX buffer occupancy
//   uart_id/din/write      registered command bus to the UART
//   grant                  one-hot current packet owner, 00 when none
//   timeout_pulse          one-cycle pulse on a forced packet end
//   stat_*                 (UART_ARB_STATS_EN only) wrapping event counters
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter logic [15:0] INIT_BAUD = 16'd2604,
   parameter int          HIGH_WM   = 2040,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   input  logic        req0_last,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   input  logic        req1_last,
   output logic        req1_ready,
   input  logic        cfg_baud_valid,
   input  logic [15:0] cfg_baud,
   output logic        cfg_baud_ready,
   input  logic [11:0] uart_txcount,
   output logic [15:0] uart_id,
   output logic [15:0] uart_din,
   output logic        uart_write,
   output logic [1:0]  grant,
   output logic        timeout_pulse
`ifdef UART_ARB_STATS_EN
   ,
   output logic [15:0] stat_bytes0,
   output logic [15:0] stat_bytes1,
   output logic [7:0]  stat_timeouts
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_FLUSH,
      S_BAUD_WAIT,
      S_BAUD_SET
   } state_t;

   localparam logic [15:0] ID_BAUD     = 16'h0200;
   localparam logic [15:0] ID_STORE    = 16'h0201;
   localparam logic [15:0] ID_FLUSH    = 16'h0202;
   // Two below the high-water mark: one byte may still be in the UART's
   // txcount pipeline when the next acceptance is decided.
   localparam logic [11:0] READY_LIMIT = 12'(HIGH_WM - 2);

   state_t      state, state_d;
   logic [1:0]  grant_d;
   logic        last_grant, last_grant_d;
   logic [15:0] id_d, din_d;
   logic        write_d;
   logic        baud_ready_d;
   logic        tpulse_d;
   logic [15:0] tcnt, tcnt_d;
   logic [17:0] guard, guard_d;
   logic [15:0] shadow, shadow_d;

   logic        sel_valid;
   logic [7:0]  sel_data;
   logic        sel_last;
   logic        stream_ok;
   logic        accept;

   // Only the current owner's signals matter; grant is one-hot or zero.
   assign sel_valid = grant[1] ? req1_valid : req0_valid;
   assign sel_data  = grant[1] ? req1_data  : req0_data;
   assign sel_last  = grant[1] ? req1_last  : req0_last;

   // uart_write high means a byte was written last cycle and the UART has not
   // yet reflected it in txcount, so acceptance skips this cycle.
   assign stream_ok  = (state == S_STREAM) && (uart_txcount <= READY_LIMIT) && !uart_write;
   assign req0_ready = grant[0] & stream_ok;
   assign req1_ready = grant[1] & stream_ok;
   assign accept     = sel_valid & stream_ok;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state;
      grant_d      = grant;
      last_grant_d = last_grant;
      id_d         = uart_id;
      din_d        = uart_din;
      write_d      = 1'b0;
      baud_ready_d = 1'b0;
      tpulse_d     = 1'b0;
      tcnt_d       = tcnt;
      guard_d      = guard;
      shadow_d     = shadow;

      case (state)
         S_IDLE: begin
            // A request still high during its own ready pulse was just served.
            if (cfg_baud_valid && !cfg_baud_ready) begin
               state_d = S_BAUD_WAIT;
               guard_d = {shadow, 2'b11};
            end else if (req0_valid || req1_valid) begin
               state_d = S_STREAM;
               tcnt_d  = '0;
               if (req0_valid && req1_valid)
                  grant_d = last_grant ? 2'b01 : 2'b10;
               else
                  grant_d = req0_valid ? 2'b01 : 2'b10;
            end
         end

         S_STREAM: begin
            if (accept) begin
               write_d = 1'b1;
               id_d    = ID_STORE;
               din_d   = {8'h00, sel_data};
               tcnt_d  = '0;
               if (sel_last)
                  state_d = S_FLUSH;
            end else if (!sel_valid) begin
               if (tcnt == TIMEOUT - 16'd1) begin
                  tcnt_d   = TIMEOUT;
                  tpulse_d = 1'b1;
                  state_d  = S_FLUSH;
               end else if (tcnt != TIMEOUT) begin
                  tcnt_d = tcnt + 16'd1;
               end
            end
         end

         S_FLUSH: begin
            write_d      = 1'b1;
            id_d         = ID_FLUSH;
            din_d        = '0;
            last_grant_d = grant[1];
            grant_d      = 2'b00;
            state_d      = S_IDLE;
         end

         S_BAUD_WAIT: begin
            // The guard is loaded with 4*(shadow+1)-1 and the transition is
            // taken on the cycle it is seen at zero, giving 4*(shadow+1)
            // drained cycles while the value still fits in 18 bits.
            if (uart_txcount != '0)
               guard_d = {shadow, 2'b11};
            else if (guard == '0)
               state_d = S_BAUD_SET;
            else
               guard_d = guard - 18'd1;
         end

         S_BAUD_SET: begin
            write_d      = 1'b1;
            id_d         = ID_BAUD;
            din_d        = cfg_baud;
            baud_ready_d = 1'b1;
            shadow_d     = cfg_baud;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state          <= S_IDLE;
         grant          <= 2'b00;
         last_grant     <= 1'b1;
         uart_id        <= '0;
         uart_din       <= '0;
         uart_write     <= 1'b0;
         cfg_baud_ready <= 1'b0;
         timeout_pulse  <= 1'b0;
         tcnt           <= '0;
         guard          <= '0;
         shadow         <= INIT_BAUD;
      end else begin
         state          <= state_d;
         grant          <= grant_d;
         last_grant     <= last_grant_d;
         uart_id        <= id_d;
         uart_din       <= din_d;
         uart_write     <= write_d;
         cfg_baud_ready <= baud_ready_d;
         timeout_pulse  <= tpulse_d;
         tcnt           <= tcnt_d;
         guard          <= guard_d;
         shadow         <= shadow_d;
      end
   end

`ifdef UART_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_bytes0   <= '0;
         stat_bytes1   <= '0;
         stat_timeouts <= '0;
      end else begin
         if (req0_valid && req0_ready)
            stat_bytes0 <= stat_bytes0 + 16'd1;
         if (req1_valid && req1_ready)
            stat_bytes1 <= stat_bytes1 + 16'd1;
         if (tpulse_d)
            stat_timeouts <= stat_timeouts + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Every accepted byte pushes its
// expected txStoreByte command (and, on the last byte, the txFlush) into a
// scoreboard queue; a monitor pops and compares each command the DUT writes.
// Grant order, throttling, baud drain timing, timeout and reset are checked
// directly. TIMEOUT is shortened to keep the run brief.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam logic [15:0] TB_TIMEOUT = 16'd300;
   localparam int          TB_INIT_BAUD = 2604;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_last, req0_ready;
   logic [7:0]  req0_data;
   logic        req1_valid, req1_last, req1_ready;
   logic [7:0]  req1_data;
   logic        cfg_baud_valid, cfg_baud_ready;
   logic [15:0] cfg_baud;
   logic [11:0] uart_txcount;
   logic [15:0] uart_id, uart_din;
   logic        uart_write;
   logic [1:0]  grant;
   logic        timeout_pulse;
`ifdef UART_ARB_STATS_EN
   logic [15:0] stat_bytes0, stat_bytes1;
   logic [7:0]  stat_timeouts;
`endif

   uart_tx_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk            (clk),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_data      (req0_data),
      .req0_last      (req0_last),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_data      (req1_data),
      .req1_last      (req1_last),
      .req1_ready     (req1_ready),
      .cfg_baud_valid (cfg_baud_valid),
      .cfg_baud       (cfg_baud),
      .cfg_baud_ready (cfg_baud_ready),
      .uart_txcount   (uart_txcount),
      .uart_id        (uart_id),
      .uart_din       (uart_din),
      .uart_write     (uart_write),
      .grant          (grant),
      .timeout_pulse  (timeout_pulse)
`ifdef UART_ARB_STATS_EN
      ,
      .stat_bytes0    (stat_bytes0),
      .stat_bytes1    (stat_bytes1),
      .stat_timeouts  (stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb[$];
   logic [1:0]  glog[$];
   int          write_count = 0;
   int          cyc = 0;
   int          byte_cyc = 0;
   int          flush_cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Command monitor and grant-change log.
   initial begin
      logic [1:0] prev_grant;
      prev_grant = 2'b00;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_grant = 2'b00;
         end else begin
            if (uart_write) begin
               write_count++;
               if (uart_id == 16'h0201) byte_cyc = cyc;
               if (uart_id == 16'h0202) flush_cyc = cyc;
               if (sb.size() == 0)
                  check("sb_unexpected_write", {uart_id, uart_din}, 32'h0);
               else
                  check("sb_cmd", {uart_id, uart_din}, sb.pop_front());
            end
            if (grant != prev_grant && grant != 2'b00) glog.push_back(grant);
            prev_grant = grant;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int port, input logic v, input logic [7:0] d, input logic l);
      if (port == 0) begin
         req0_valid = v; req0_data = d; req0_last = l;
      end else begin
         req1_valid = v; req1_data = d; req1_last = l;
      end
   endtask

   // Offer one byte, wait (bounded) for the handshake, record expectations.
   task automatic send_byte(input int port, input logic [7:0] data, input logic last);
      int   waited;
      logic rdy;
      logic done;
      waited = 0;
      done   = 1'b0;
      set_req(port, 1'b1, data, last);
      while (!done) begin
         @(negedge clk);
         rdy = (port == 0) ? req0_ready : req1_ready;
         if (rdy) begin
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 5000) begin
               check("handshake_wait", 32'(rdy), 32'h1);
               set_req(port, 1'b0, 8'h00, 1'b0);
               return;
            end
         end
      end
      check("grant_owner", 32'(grant), (port == 0) ? 32'h1 : 32'h2);
      sb.push_back({16'h0201, 8'h00, data});
      if (last) sb.push_back({16'h0202, 16'h0000});
      @(posedge clk); #1;
   endtask

   task automatic drive_pkt(input int port, input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++)
         send_byte(port, 8'(int'(base) + i), (i == n - 1));
      set_req(port, 1'b0, 8'h00, 1'b0);
   endtask

   // Negedges until sig goes high, bounded; returns the bound+1 if never.
   task automatic wait_cycles(input int which, input int bound, output int n);
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n <= bound) begin
         @(negedge clk);
         n++;
         hit = (which == 0) ? cfg_baud_ready : timeout_pulse;
      end
   endtask

   initial begin
      int         wc, hits, n;
      logic [1:0] g;

      reset = 1'b1;
      req0_valid = 0; req0_data = 0; req0_last = 0;
      req1_valid = 0; req1_data = 0; req1_last = 0;
      cfg_baud_valid = 0; cfg_baud = 0; uart_txcount = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_write", 32'(uart_write), 32'h0);
      check("rst_id_din", {uart_id, uart_din}, 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_ready", {29'h0, req0_ready, req1_ready, cfg_baud_ready}, 32'h0);
      check("rst_tpulse", 32'(timeout_pulse), 32'h0);

      // Single 3-byte packet from req0.
      @(posedge clk); #1;
      glog.delete();
      drive_pkt(0, 8'h41, 3);
      @(negedge clk);
      @(negedge clk);
      check("pkt_grant_after", 32'(grant), 32'h0);
      @(posedge clk); #1;
      check("pkt_flush_gap", 32'(flush_cyc - byte_cyc), 32'h1);
      check("pkt_writes", 32'(write_count), 32'h4);
      check("pkt_grant_first", 32'(glog.size() > 0 ? glog[0] : 2'b00), 32'h1);

      // Both requesters continuously valid, 2-byte packets. req0 owned the
      // previous packet, so req1 wins first and ownership alternates.
      glog.delete();
      fork
         begin drive_pkt(0, 8'h20, 2); drive_pkt(0, 8'h22, 2); end
         begin drive_pkt(1, 8'h30, 2); drive_pkt(1, 8'h32, 2); end
      join
      repeat (3) @(posedge clk); #1;
      check("rr_count", 32'(glog.size()), 32'h4);
      g = 2'b10;
      for (int i = 0; i < glog.size(); i++) begin
         check("rr_order", 32'(glog[i]), 32'(g));
         g = {g[0], g[1]};
      end

      // Throttle: 2039 stalls, 2038 allows, 2000 resumes.
      send_byte(0, 8'h10, 1'b0);
      uart_txcount = 12'd2039;
      set_req(0, 1'b1, 8'h11, 1'b0);
      @(posedge clk); #1;
      wc   = write_count;
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (req0_ready) hits++;
      end
      check("stall_ready_hits", 32'(hits), 32'h0);
      @(posedge clk); #1;
      check("stall_writes", 32'(write_count - wc), 32'h0);
      set_req(0, 1'b0, 8'h00, 1'b0);
      uart_txcount = 12'd2038;
      @(negedge clk);
      check("ready_at_2038", 32'(req0_ready), 32'h1);
      @(posedge clk); #1;
      uart_txcount = 12'd2000;
      send_byte(0, 8'h11, 1'b0);
      send_byte(0, 8'h12, 1'b1);
      set_req(0, 1'b0, 8'h00, 1'b0);

      // Baud change requested mid-packet while the line is busy.
      uart_txcount = 12'd5;
      fork
         drive_pkt(1, 8'h60, 3);
         begin
            repeat (2) @(posedge clk);
            #1 cfg_baud = 16'd325;
            cfg_baud_valid = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      wc   = write_count;
      hits = 0;
      repeat (50) begin
         @(negedge clk);
         if (cfg_baud_ready) hits++;
      end
      @(posedge clk); #1;
      check("baud_busy_writes", 32'(write_count - wc), 32'h0);
      check("baud_busy_ready", 32'(hits), 32'h0);
      sb.push_back({16'h0200, 16'd325});
      uart_txcount = 12'd0;
      // Guard of 4*(shadow+1) drained cycles, one BAUD_SET cycle, then the
      // registered pulse is visible.
      wait_cycles(0, 4 * (TB_INIT_BAUD + 1) + 50, n);
      cfg_baud_valid = 1'b0;
      check("baud_guard_cycles", 32'(n), 32'(4 * (TB_INIT_BAUD + 1) + 2));
      @(negedge clk);
      check("baud_ready_width", 32'(cfg_baud_ready), 32'h0);

      // Second change starts from IDLE with the line drained: one extra
      // cycle for the IDLE decision, guard now based on 325.
      @(posedge clk); #1;
      cfg_baud = 16'd100;
      cfg_baud_valid = 1'b1;
      sb.push_back({16'h0200, 16'd100});
      wait_cycles(0, 4 * (325 + 1) + 50, n);
      cfg_baud_valid = 1'b0;
      check("baud2_guard_cycles", 32'(n), 32'(4 * (325 + 1) + 3));

      // Timeout: req1 sends one non-last byte then goes quiet.
      @(posedge clk); #1;
      send_byte(1, 8'h77, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      sb.push_back({16'h0202, 16'h0000});
      wait_cycles(1, int'(TB_TIMEOUT) + 50, n);
      check("timeout_cycles", 32'(n), 32'(int'(TB_TIMEOUT) + 1));
      @(negedge clk);
      check("timeout_pulse_width", 32'(timeout_pulse), 32'h0);
      check("timeout_grant", 32'(grant), 32'h0);
`ifdef UART_ARB_STATS_EN
      check("stat_timeouts", 32'(stat_timeouts), 32'h1);
`endif

      // Reset mid-packet after two bytes: no flush, req0 wins next.
      @(posedge clk); #1;
      send_byte(0, 8'hA1, 1'b0);
      send_byte(0, 8'hA2, 1'b0);
      set_req(0, 1'b0, 8'h00, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("mid_rst_write", 32'(uart_write), 32'h0);
      check("mid_rst_id_din", {uart_id, uart_din}, 32'h0);
      check("mid_rst_grant", 32'(grant), 32'h0);
      check("mid_rst_ready", {29'h0, req0_ready, req1_ready, cfg_baud_ready}, 32'h0);
      @(posedge clk); #1;
      glog.delete();
      fork
         drive_pkt(0, 8'hB0, 1);
         drive_pkt(1, 8'hC0, 1);
      join
      repeat (3) @(posedge clk); #1;
      check("post_rst_grants", 32'(glog.size()), 32'h2);
      if (glog.size() >= 2) begin
         check("post_rst_first", 32'(glog[0]), 32'h1);
         check("post_rst_second", 32'(glog[1]), 32'h2);
      end

      repeat (5) @(posedge clk); #1;
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
